// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm -- match controller feeding the screen selector.
//
// Runs one match: START -> alternating SHOOTER/KEEPER kicks -> WINNER/LOOSER.
// Each resolved kick is held on screen for HOLD_CYCLES cycles before the
// controller moves on. After every KEEPER kick a round is complete. After
// ROUNDS regulation rounds a tie continues as sudden death, one round at a time.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start_btn      1-cycle pulse; starts a match while in START
//   mode_sel       0=SOLO, 1=MULTI; latched when start_btn is accepted
//   restart        1-cycle pulse; returns to START from any state (mode kept)
//   shot_done      1-cycle pulse; the current kick is resolved
//   shot_goal      qualifies shot_done; 1 = goal
//   game_state     g_state encoding from game_pkg
//   game_mode      latched mode
//   score          player points (saturating)
//   score_opp      opponent points (saturating)
//   round_counter  completed rounds (saturating)
//   is_scored      result of the last accepted kick
//
// All outputs are registered.

package game_pkg;
  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOOSER  = 3'd4
  } g_state;

  localparam logic SOLO  = 1'b0;
  localparam logic MULTI = 1'b1;
endpackage

module game_ctrl_fsm #(
  parameter int ROUNDS      = 5,
  parameter int SCORE_W     = 4,
  parameter int ROUND_W     = 4,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               mode_sel,
  input  logic               restart,
  input  logic               shot_done,
  input  logic               shot_goal,
  output logic [2:0]         game_state,
  output logic               game_mode,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] score_opp,
  output logic [ROUND_W-1:0] round_counter,
  output logic               is_scored
);
  import game_pkg::*;

  // The counter is loaded with HOLD_CYCLES-1, so clog2(HOLD_CYCLES) bits suffice.
  localparam int                 HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ROUND_W-1:0] ROUNDS_L  = ROUND_W'(ROUNDS);

  g_state               state_q, state_n;
  logic                 mode_q, mode_n;
  logic [SCORE_W-1:0]   score_q, score_n;
  logic [SCORE_W-1:0]   opp_q, opp_n;
  logic [ROUND_W-1:0]   round_q, round_n;
  logic                 is_q, is_n;
  logic                 hold_q, hold_n;
  logic [HOLD_W-1:0]    cnt_q, cnt_n;
  logic [ROUND_W-1:0]   round_inc;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                 input logic inc);
    if (inc && (v != '1)) return v + SCORE_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
      mode_q  <= MULTI;
      score_q <= '0;
      opp_q   <= '0;
      round_q <= '0;
      is_q    <= 1'b0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      score_q <= score_n;
      opp_q   <= opp_n;
      round_q <= round_n;
      is_q    <= is_n;
      hold_q  <= hold_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    score_n   = score_q;
    opp_n     = opp_q;
    round_n   = round_q;
    is_n      = is_q;
    hold_n    = hold_q;
    cnt_n     = cnt_q;
    round_inc = (round_q == '1) ? round_q : round_q + ROUND_W'(1);

    if (restart) begin
      // restart outranks every other event in the same cycle
      state_n = START;
      score_n = '0;
      opp_n   = '0;
      round_n = '0;
      is_n    = 1'b0;
      hold_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        START: begin
          if (start_btn) begin
            state_n = SHOOTER;
            mode_n  = mode_sel;
            score_n = '0;
            opp_n   = '0;
            round_n = '0;
            is_n    = 1'b0;
          end
        end

        SHOOTER, KEEPER: begin
          if (hold_q) begin
            if (cnt_q == '0) begin
              hold_n = 1'b0;
              if (state_q == SHOOTER) begin
                state_n = KEEPER;
              end else begin
                // Round just completed: decide on the incremented count.
                round_n = round_inc;
                if (round_inc < ROUNDS_L)   state_n = SHOOTER;
                else if (score_q > opp_q)   state_n = WINNER;
                else if (score_q < opp_q)   state_n = LOOSER;
                else                        state_n = SHOOTER;
              end
            end else begin
              cnt_n = cnt_q - HOLD_W'(1);
            end
          end else if (shot_done) begin
            is_n   = shot_goal;
            hold_n = 1'b1;
            cnt_n  = HOLD_LOAD;
            if (state_q == SHOOTER) score_n = sat_add(score_q, shot_goal);
            else                    opp_n   = sat_add(opp_q, shot_goal);
          end
        end

        WINNER, LOOSER: ;

        default: state_n = START;
      endcase
    end
  end

  assign game_state    = state_q;
  assign game_mode     = mode_q;
  assign score         = score_q;
  assign score_opp     = opp_q;
  assign round_counter = round_q;
  assign is_scored     = is_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Testbench for game_ctrl_fsm with HOLD_CYCLES=4 and ROUNDS=2. Narrow counters
// make saturation reachable in a short run.
module tb_game_ctrl_fsm;
  import game_pkg::*;

  localparam int ROUNDS  = 2;
  localparam int SCORE_W = 3;
  localparam int ROUND_W = 3;
  localparam int HOLD    = 4;
  localparam int SMAX    = (1 << SCORE_W) - 1;
  localparam int RMAX    = (1 << ROUND_W) - 1;

  logic clk = 1'b0;
  logic rst, start_btn, mode_sel, restart, shot_done, shot_goal;
  logic [2:0]         game_state;
  logic               game_mode;
  logic [SCORE_W-1:0] score, score_opp;
  logic [ROUND_W-1:0] round_counter;
  logic               is_scored;

  game_ctrl_fsm #(
    .ROUNDS(ROUNDS),
    .SCORE_W(SCORE_W),
    .ROUND_W(ROUND_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .mode_sel(mode_sel),
    .restart(restart),
    .shot_done(shot_done),
    .shot_goal(shot_goal),
    .game_state(game_state),
    .game_mode(game_mode),
    .score(score),
    .score_opp(score_opp),
    .round_counter(round_counter),
    .is_scored(is_scored)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: kick/round bookkeeping in plain integers.
  g_state m_state = START;
  bit     m_mode  = 1'b1;
  int     m_score = 0, m_opp = 0, m_round = 0, m_hold_left = 0;
  bit     m_is    = 1'b0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_score = 0; m_opp = 0; m_round = 0; m_is = 1'b0; m_hold_left = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit ms,
                            input bit rs, input bit sd, input bit sg);
    if (r) begin
      m_state = START; m_mode = 1'b1; model_clear();
    end else if (rs) begin
      m_state = START; model_clear();
    end else if (m_state == START) begin
      if (st) begin m_state = SHOOTER; m_mode = ms; model_clear(); end
    end else if (m_state == SHOOTER || m_state == KEEPER) begin
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          if (m_state == SHOOTER) m_state = KEEPER;
          else begin
            m_round = min_i(m_round + 1, RMAX);
            if (m_round < ROUNDS)       m_state = SHOOTER;
            else if (m_score > m_opp)   m_state = WINNER;
            else if (m_score < m_opp)   m_state = LOOSER;
            else                        m_state = SHOOTER;
          end
        end
      end else if (sd) begin
        m_is = sg;
        if (m_state == SHOOTER) m_score = min_i(m_score + int'(sg), SMAX);
        else                    m_opp   = min_i(m_opp + int'(sg), SMAX);
        m_hold_left = HOLD;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model.state", int'(game_state), int'(m_state));
    chk("model.mode",  int'(game_mode), int'(m_mode));
    chk("model.score", int'(score), m_score);
    chk("model.opp",   int'(score_opp), m_opp);
    chk("model.round", int'(round_counter), m_round);
    chk("model.is",    int'(is_scored), int'(m_is));
  endtask

  // One clock: drive for this edge, advance the model, sample 1 ns later.
  task automatic cyc(input bit r, input bit st, input bit ms,
                     input bit rs, input bit sd, input bit sg);
    rst = r; start_btn = st; mode_sel = ms; restart = rs; shot_done = sd; shot_goal = sg;
    @(posedge clk);
    model_step(r, st, ms, rs, sd, sg);
    #1;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic kick(input bit goal);
    cyc(0, 0, 0, 0, 1, goal);
    idle(HOLD);
  endtask

  task automatic expect_now(input string tag, input int st, input int sc,
                            input int op, input int rd);
    chk({tag, ".state"}, int'(game_state), st);
    chk({tag, ".score"}, int'(score), sc);
    chk({tag, ".opp"},   int'(score_opp), op);
    chk({tag, ".round"}, int'(round_counter), rd);
  endtask

  typedef struct {
    bit r, st, ms, rs, sd, sg;
    int es, em, esc, eop, erd, eis;
  } vec_t;

  vec_t tbl[15];

  initial begin
    rst = 1'b0; start_btn = 1'b0; mode_sel = 1'b0;
    restart = 1'b0; shot_done = 1'b0; shot_goal = 1'b0;

    //            r st ms rs sd sg   state        mode sc op rd is
    tbl[0]  = '{1, 0, 0, 0, 0, 0, int'(START),   1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, int'(SHOOTER), 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 1, int'(SHOOTER), 0, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 1, int'(SHOOTER), 0, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, int'(SHOOTER), 0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, int'(SHOOTER), 0, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, int'(KEEPER),  0, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, int'(KEEPER),  0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, int'(KEEPER),  0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, int'(KEEPER),  0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, int'(KEEPER),  0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, int'(SHOOTER), 0, 1, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 1, 1, 1, int'(START),   0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 1, int'(START),   0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 1, 0, 0, 0, int'(SHOOTER), 1, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].st, tbl[i].ms, tbl[i].rs, tbl[i].sd, tbl[i].sg);
      chk($sformatf("vec%0d.state", i), int'(game_state), tbl[i].es);
      chk($sformatf("vec%0d.mode", i),  int'(game_mode), tbl[i].em);
      chk($sformatf("vec%0d.score", i), int'(score), tbl[i].esc);
      chk($sformatf("vec%0d.opp", i),   int'(score_opp), tbl[i].eop);
      chk($sformatf("vec%0d.round", i), int'(round_counter), tbl[i].erd);
      chk($sformatf("vec%0d.is", i),    int'(is_scored), tbl[i].eis);
    end

    // 2-0 win, then inputs ignored in WINNER
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    kick(1); kick(0); kick(1); kick(0);
    expect_now("win20", int'(WINNER), 2, 0, 2);
    cyc(0, 1, 1, 0, 1, 1);
    expect_now("win_hold", int'(WINNER), 2, 0, 2);
    chk("win_hold.mode", int'(game_mode), 0);

    // 0-2 loss
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    kick(0); kick(1); kick(0); kick(1);
    expect_now("lose02", int'(LOOSER), 0, 2, 2);

    // 1-1 tie -> sudden death, then win in round 3
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    kick(1); kick(1); kick(0); kick(0);
    expect_now("tie", int'(SHOOTER), 1, 1, 2);
    kick(1); kick(0);
    expect_now("sudden", int'(WINNER), 2, 1, 3);

    // restart with shot_done mid-KEEPER hold; mode kept
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    kick(1);
    cyc(0, 0, 0, 0, 1, 1);
    idle(1);
    cyc(0, 0, 0, 1, 1, 1);
    expect_now("restart", int'(START), 0, 0, 0);
    chk("restart.mode", int'(game_mode), 1);
    chk("restart.is",   int'(is_scored), 0);

    // rst during hold, then shot_done in START ignored
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    expect_now("rst_hold", int'(START), 0, 0, 0);
    chk("rst_hold.mode", int'(game_mode), 1);
    cyc(0, 0, 0, 0, 1, 1);
    expect_now("start_ign", int'(START), 0, 0, 0);
    chk("start_ign.is", int'(is_scored), 0);
    // no stale hold after rst: a fresh match accepts a kick at once
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("post_rst.score", int'(score), 1);

    // saturation: every kick scores, tie persists past all-ones
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin kick(1); kick(1); end
    expect_now("sat", int'(SHOOTER), SMAX, SMAX, RMAX);

    // randomized run against the model
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 5) == 0),
          1'($urandom),
          ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 2) == 0),
          1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
